digit_select_k: RTL

DIGIT_SELECT_K -- requirements
Module: digit_select_k

---
 rtl/digit_select_k_pkg.sv | 19 +
 rtl/digit_stack.sv | 63 ++++++
 rtl/digit_select_k.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/digit_select_k_pkg.sv
// Shared definitions for the digit_select_k block: FSM encoding, BCD width,
// the base-10 constant and a BCD range helper.
package digit_select_k_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_POP    = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    localparam int BCD_W    = 4;
    localparam int BASE_TEN = 10;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/digit_stack.sv
// K_SEL-deep BCD digit stack with push/pop, random read index and depth.
module digit_stack
    import digit_select_k_pkg::*;
#(
    parameter int K_SEL = 12
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [BCD_W-1:0]             push_digit,
    input  logic [$clog2(K_SEL+1)-1:0]   rd_idx,
    output logic [BCD_W-1:0]             rd_digit,
    output logic [BCD_W-1:0]             top_digit,
    output logic [$clog2(K_SEL+1)-1:0]   depth
);

    localparam int DEP_W = $clog2(K_SEL + 1);
    localparam int AW    = (K_SEL > 1) ? $clog2(K_SEL) : 1;
    localparam logic [DEP_W-1:0] K_CNT = DEP_W'(K_SEL);

    logic [BCD_W-1:0] mem_r [K_SEL];
    logic [DEP_W-1:0] depth_r;

    // Stack storage and depth pointer; clr wins over push/pop.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            depth_r <= {DEP_W{1'b0}};
            for (int i = 0; i < K_SEL; i++) begin
                mem_r[i] <= {BCD_W{1'b0}};
            end
        end else if (clr) begin
            depth_r <= {DEP_W{1'b0}};
        end else if (push && (depth_r < K_CNT)) begin
            mem_r[AW'(depth_r)] <= push_digit;
            depth_r             <= depth_r + DEP_W'(1'b1);
        end else if (pop && (depth_r != {DEP_W{1'b0}})) begin
            depth_r <= depth_r - DEP_W'(1'b1);
        end else begin
            depth_r <= depth_r;
        end
    end

    // Read ports; out-of-range indices read as zero.
    always_comb begin
        rd_digit  = {BCD_W{1'b0}};
        top_digit = {BCD_W{1'b0}};
        if (rd_idx < K_CNT) begin
            rd_digit = mem_r[AW'(rd_idx)];
        end else begin
            rd_digit = {BCD_W{1'b0}};
        end
        if (depth_r != {DEP_W{1'b0}}) begin
            top_digit = mem_r[AW'(depth_r - DEP_W'(1'b1))];
        end else begin
            top_digit = {BCD_W{1'b0}};
        end
    end

    assign depth = depth_r;

endmodule

// File: rtl/digit_select_k.sv
// Streams fixed-length BCD lines, emits the largest K_SEL-digit subsequence of
// each line (monotonic stack) and keeps a running total of the emitted values.
module digit_select_k
    import digit_select_k_pkg::*;
#(
    parameter int N_DIGITS = 100,
    parameter int K_SEL    = 12,
    parameter int SUM_W    = 64
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BCD_W-1:0] in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BCD_W-1:0] out_digit,
    output logic             out_last,
    input  logic             clr_total,
    output logic [SUM_W-1:0] total,
    output logic             err
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DEP_W = $clog2(K_SEL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [DEP_W-1:0] K_CNT     = DEP_W'(K_SEL);
    localparam logic [DEP_W-1:0] LAST_EMIT = DEP_W'(K_SEL - 1);

    state_t           state_r, state_next_s;
    logic             in_ready_r;
    logic [BCD_W-1:0] pend_r;
    logic [IDX_W-1:0] idx_r;
    logic             err_r;
    logic [DEP_W-1:0] emit_idx_r;
    logic             out_valid_r;
    logic [BCD_W-1:0] out_digit_r;
    logic             out_last_r;
    logic [SUM_W-1:0] value_r;
    logic [SUM_W-1:0] total_r;

    logic             stk_clr_s, stk_push_s, stk_pop_s;
    logic [DEP_W-1:0] stk_rd_idx_s, stk_depth_s;
    logic [BCD_W-1:0] stk_rd_digit_s, stk_top_s;

    logic             accept_s, at_last_s, drop_s, fmt_err_s;
    logic             out_xfer_s, line_done_s, can_pop_s;
    logic [31:0]      room_s;
    logic [BCD_W-1:0] first_digit_s;
    logic [SUM_W-1:0] line_value_s;

    digit_stack #(.K_SEL(K_SEL)) u_stack (
        .sysclk     (sysclk),
        .reset      (reset),
        .clr        (stk_clr_s),
        .push       (stk_push_s),
        .pop        (stk_pop_s),
        .push_digit (pend_r),
        .rd_idx     (stk_rd_idx_s),
        .rd_digit   (stk_rd_digit_s),
        .top_digit  (stk_top_s),
        .depth      (stk_depth_s)
    );

    assign accept_s    = in_valid & in_ready_r;
    assign at_last_s   = (idx_r == LAST_IDX);
    assign drop_s      = accept_s & ((in_last & ~at_last_s) | ~bcd_valid(in_digit));
    assign fmt_err_s   = drop_s | (accept_s & ~in_last & at_last_s);
    assign out_xfer_s  = out_valid_r & out_ready;
    assign line_done_s = out_xfer_s & out_last_r;
    assign line_value_s = value_r * SUM_W'(BASE_TEN) + SUM_W'(out_digit_r);

    // Popping is only allowed while the remaining digits can still refill K_SEL slots.
    assign room_s    = 32'(stk_depth_s) + 32'(N_DIGITS) - 32'(idx_r) - 32'd1;
    assign can_pop_s = (stk_depth_s != {DEP_W{1'b0}}) & (stk_top_s < pend_r) &
                       (room_s >= 32'(K_SEL));
    assign first_digit_s = (stk_depth_s == {DEP_W{1'b0}}) ? pend_r : stk_rd_digit_s;

    // Next-state and stack control.
    always_comb begin
        state_next_s = state_r;
        stk_push_s   = 1'b0;
        stk_pop_s    = 1'b0;
        stk_clr_s    = 1'b0;
        stk_rd_idx_s = {DEP_W{1'b0}};
        case (state_r)
            ST_ACCEPT: begin
                if (drop_s) begin
                    stk_clr_s = 1'b1;
                end else if (accept_s) begin
                    state_next_s = ST_POP;
                end else begin
                    state_next_s = ST_ACCEPT;
                end
            end
            ST_POP: begin
                if (can_pop_s) begin
                    stk_pop_s = 1'b1;
                end else begin
                    stk_push_s = (stk_depth_s < K_CNT);
                    if (at_last_s) begin
                        state_next_s = ST_EMIT;
                    end else begin
                        state_next_s = ST_ACCEPT;
                    end
                end
            end
            ST_EMIT: begin
                stk_rd_idx_s = emit_idx_r + DEP_W'(1'b1);
                if (line_done_s) begin
                    stk_clr_s    = 1'b1;
                    state_next_s = ST_ACCEPT;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: begin
                state_next_s = ST_ACCEPT;
            end
        endcase
    end

    // Control registers: state, ready, pending digit, line index, sticky error.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r    <= ST_ACCEPT;
            in_ready_r <= 1'b0;
            pend_r     <= {BCD_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == ST_ACCEPT);
            if (accept_s) begin
                pend_r <= in_digit;
            end else begin
                pend_r <= pend_r;
            end
            if (drop_s || line_done_s) begin
                idx_r <= {IDX_W{1'b0}};
            end else if ((state_r == ST_POP) && !can_pop_s && !at_last_s) begin
                idx_r <= idx_r + IDX_W'(1'b1);
            end else begin
                idx_r <= idx_r;
            end
            if (fmt_err_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Output digit register and line value accumulation.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_digit_r <= {BCD_W{1'b0}};
            out_last_r  <= 1'b0;
            emit_idx_r  <= {DEP_W{1'b0}};
            value_r     <= {SUM_W{1'b0}};
        end else if ((state_r == ST_POP) && (state_next_s == ST_EMIT)) begin
            out_valid_r <= 1'b1;
            out_digit_r <= first_digit_s;
            out_last_r  <= (LAST_EMIT == {DEP_W{1'b0}});
            emit_idx_r  <= {DEP_W{1'b0}};
            value_r     <= {SUM_W{1'b0}};
        end else if (line_done_s) begin
            out_valid_r <= 1'b0;
            out_digit_r <= {BCD_W{1'b0}};
            out_last_r  <= 1'b0;
            emit_idx_r  <= {DEP_W{1'b0}};
            value_r     <= {SUM_W{1'b0}};
        end else if (out_xfer_s) begin
            out_digit_r <= stk_rd_digit_s;
            out_last_r  <= ((emit_idx_r + DEP_W'(1'b1)) == LAST_EMIT);
            emit_idx_r  <= emit_idx_r + DEP_W'(1'b1);
            value_r     <= line_value_s;
        end else begin
            out_valid_r <= out_valid_r;
            out_digit_r <= out_digit_r;
            out_last_r  <= out_last_r;
            emit_idx_r  <= emit_idx_r;
            value_r     <= value_r;
        end
    end

    // Running total; a clear coinciding with line completion keeps that line's value.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            total_r <= {SUM_W{1'b0}};
        end else if (line_done_s) begin
            total_r <= clr_total ? line_value_s : (total_r + line_value_s);
        end else if (clr_total) begin
            total_r <= {SUM_W{1'b0}};
        end else begin
            total_r <= total_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_digit = out_digit_r;
    assign out_last  = out_last_r;
    assign total     = total_r;
    assign err       = err_r;

endmodule
